// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector front end and the fp32 multiplier.
// Holds the opcodes, the assembler states and the identity matrix helper.
package mv_pkg;

  localparam int MV_IDW     = 8;
  localparam int MV_LATENCY = 4;

  localparam logic [7:0]  OP_MATRIX = 8'h01;
  localparam logic [7:0]  OP_VERTEX = 8'h02;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  localparam int MAT_WORDS = 16;
  localparam int VTX_WORDS = 4;

  typedef enum logic [1:0] {
    HDR,
    MAT,
    VTX,
    DRAIN
  } asm_state_e;

  // Row-major 4x4 identity; the diagonal words sit at indices 0, 5, 10 and 15.
  function automatic logic [511:0] identity_mat();
    logic [511:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[(i * 5) * 32 +: 32] = FP32_ONE;
    end
    return m;
  endfunction

endpackage

// File: rtl/mv_input_assembler.sv
// Parses the 32-bit matrix/vertex word stream feeding mv_mul_4x4_fp32 and
// swaps in a new matrix only once no vertex can still be inside the multiplier.
module mv_input_assembler
  import mv_pkg::*;
#(
  parameter int IDW     = MV_IDW,
  parameter int LATENCY = MV_LATENCY
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [31:0]    s_data,
  input  logic           err_clr,
  output logic [511:0]   m_mat,
  output logic           in_valid,
  output logic [IDW-1:0] in_vertex_id,
  output logic [31:0]    vx,
  output logic [31:0]    vy,
  output logic [31:0]    vz,
  output logic [31:0]    vw,
  output logic           matrix_busy,
  output logic           err
);

  localparam int IW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [IW-1:0] IDLE_SAT = IW'(LATENCY);

  asm_state_e     state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic [511:0]   mat_q, mat_d;
  logic [31:0]    shadow_q [MAT_WORDS];
  logic [31:0]    shadow_d [MAT_WORDS];
  logic [31:0]    vbuf_q [VTX_WORDS];
  logic [31:0]    vbuf_d [VTX_WORDS];
  logic [IDW-1:0] id_buf_q, id_buf_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    vx_q, vx_d, vy_q, vy_d, vz_q, vz_d, vw_q, vw_d;
  logic           in_valid_q, in_valid_d;
  logic           err_q, err_d;

  logic       hs;
  logic [7:0] opcode;

  assign s_ready = (state_q != DRAIN);
  assign hs      = s_valid && s_ready;
  assign opcode  = s_data[31:24];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mat_d      = mat_q;
    shadow_d   = shadow_q;
    vbuf_d     = vbuf_q;
    id_buf_d   = id_buf_q;
    id_d       = id_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    vz_d       = vz_q;
    vw_d       = vw_q;
    in_valid_d = 1'b0;
    err_d      = err_clr ? 1'b0 : err_q;

    // Cycles since the last vertex was handed to the multiplier, saturating.
    if (in_valid_q) begin
      idle_d = '0;
    end else if (idle_q == IDLE_SAT) begin
      idle_d = idle_q;
    end else begin
      idle_d = idle_q + IW'(1);
    end

    case (state_q)
      HDR: begin
        if (hs) begin
          cnt_d = '0;
          if (opcode == OP_MATRIX) begin
            state_d = MAT;
          end else if (opcode == OP_VERTEX) begin
            state_d  = VTX;
            id_buf_d = s_data[IDW-1:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MAT: begin
        if (hs) begin
          shadow_d[cnt_q] = s_data;
          cnt_d           = cnt_q + 4'd1;
          if (cnt_q == 4'(MAT_WORDS - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (idle_q >= IDLE_SAT) begin
          for (int i = 0; i < MAT_WORDS; i++) begin
            mat_d[i * 32 +: 32] = shadow_q[i];
          end
          state_d = HDR;
        end
      end
      VTX: begin
        if (hs) begin
          vbuf_d[cnt_q[1:0]] = s_data;
          cnt_d              = cnt_q + 4'd1;
          // Outputs only move on the final word so a vertex is never torn.
          if (cnt_q == 4'(VTX_WORDS - 1)) begin
            state_d    = HDR;
            cnt_d      = '0;
            in_valid_d = 1'b1;
            id_d       = id_buf_q;
            vx_d       = vbuf_d[0];
            vy_d       = vbuf_d[1];
            vz_d       = vbuf_d[2];
            vw_d       = vbuf_d[3];
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HDR;
      cnt_q      <= '0;
      idle_q     <= IDLE_SAT;
      mat_q      <= identity_mat();
      id_q       <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      vz_q       <= '0;
      vw_q       <= '0;
      in_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      mat_q      <= mat_d;
      id_q       <= id_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      vz_q       <= vz_d;
      vw_q       <= vw_d;
      in_valid_q <= in_valid_d;
      err_q      <= err_d;
    end
  end

  // Packet staging storage; its contents are meaningless after a reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
    vbuf_q   <= vbuf_d;
    id_buf_q <= id_buf_d;
  end

  assign m_mat        = mat_q;
  assign in_valid     = in_valid_q;
  assign in_vertex_id = id_q;
  assign vx           = vx_q;
  assign vy           = vy_q;
  assign vz           = vz_q;
  assign vw           = vw_q;
  assign matrix_busy  = (state_q == MAT) || (state_q == DRAIN);
  assign err          = err_q;

endmodule

// File: tb/tb_mv_input_assembler.sv
// Scoreboard bench for mv_input_assembler: drivers queue expected vertices and
// matrices, a negedge monitor pops and compares whenever the DUT presents them.
module tb_mv_input_assembler;
  import mv_pkg::*;

  localparam int IDW     = 8;
  localparam int LATENCY = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [31:0]    s_data = '0;
  logic           err_clr = 1'b0;
  logic [511:0]   m_mat;
  logic           in_valid;
  logic [IDW-1:0] in_vertex_id;
  logic [31:0]    vx, vy, vz, vw;
  logic           matrix_busy;
  logic           err;

  mv_input_assembler #(.IDW(IDW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .err_clr(err_clr), .m_mat(m_mat), .in_valid(in_valid), .in_vertex_id(in_vertex_id),
    .vx(vx), .vy(vy), .vz(vz), .vw(vw), .matrix_busy(matrix_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    x;
    logic [31:0]    y;
    logic [31:0]    z;
    logic [31:0]    w;
  } vtx_t;

  vtx_t         expVtx[$];
  logic [511:0] expMat[$];
  logic [511:0] identMat;
  logic [511:0] prevMat;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int prevPulse = 0;
  int lastPulse = -100;
  bit checkSpacing = 1'b0;
  bit spacingPrimed = 1'b0;
  bit checkGap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: vertex pulses and matrix changes are matched against the queues.
  always @(negedge clk) begin
    vtx_t e;
    if (in_valid) begin
      if (expVtx.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected in_valid: got pulse id %0h, expected none", in_vertex_id);
      end else begin
        e = expVtx.pop_front();
        checkOutput("vertex id", in_vertex_id, e.id);
        checkOutput("vx", vx, e.x);
        checkOutput("vy", vy, e.y);
        checkOutput("vz", vz, e.z);
        checkOutput("vw", vw, e.w);
      end
      if (checkSpacing) begin
        if (spacingPrimed) checkOutput("pulse spacing", cyc - prevPulse, 5);
        spacingPrimed = 1'b1;
        prevPulse = cyc;
      end
      lastPulse = cyc;
    end
    if (m_mat !== prevMat) begin
      if (expMat.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected m_mat change: got %0h, expected %0h", m_mat, prevMat);
      end else begin
        checkOutput("m_mat", m_mat, expMat.pop_front());
      end
      if (checkGap) checkOutput("commit gap >= LATENCY", (cyc - lastPulse) >= LATENCY, 1);
      prevMat = m_mat;
    end
  end

  // Presents one word from a negedge and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic [31:0] w);
    int n;
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake timeout: got s_ready=0, expected 1 within 100 cycles");
    end
    @(negedge clk);
  endtask

  task automatic sendVertex(input logic [IDW-1:0] id, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z, input logic [31:0] w, input bit gaps);
    vtx_t e;
    logic [31:0] words [4];
    e.id = id; e.x = x; e.y = y; e.z = z; e.w = w;
    expVtx.push_back(e);
    words[0] = x; words[1] = y; words[2] = z; words[3] = w;
    applyStimulus({OP_VERTEX, 24'(id)});
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      applyStimulus(words[i]);
    end
  endtask

  task automatic sendMatrix(input logic [31:0] base, input bit checkBusy, output int drainCycles);
    logic [511:0] m;
    int n;
    for (int i = 0; i < 16; i++) m[i * 32 +: 32] = base + 32'(i);
    expMat.push_back(m);
    applyStimulus({OP_MATRIX, 24'h0});
    for (int i = 0; i < 16; i++) begin
      applyStimulus(m[i * 32 +: 32]);
      if (checkBusy) checkOutput("matrix_busy in MAT", matrix_busy, 1);
    end
    s_valid = 1'b0;
    n = 0;
    while (!s_ready && n < 100) begin
      if (checkBusy) checkOutput("matrix_busy in DRAIN", matrix_busy, 1);
      @(negedge clk);
      n++;
    end
    drainCycles = n;
    checkOutput("matrix_busy after commit", matrix_busy, 0);
  endtask

  initial begin
    int dc;
    int n;
    identMat = '0;
    for (int i = 0; i < 4; i++) identMat[i * 160 +: 32] = 32'h3F80_0000;
    prevMat = identMat;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("reset m_mat", m_mat, identMat);
    checkOutput("reset in_valid", in_valid, 0);
    checkOutput("reset vertex id", in_vertex_id, 0);
    checkOutput("reset vx", vx, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset matrix_busy", matrix_busy, 0);
    checkOutput("reset s_ready", s_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single vertex");
    sendVertex(8'd7, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 1'b0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("vx holds after pulse", vx, 32'h3F80_0000);
    checkOutput("m_mat identity after vertex", m_mat, identMat);

    $display("[TB] matrix load with idle multiplier");
    repeat (6) @(negedge clk);
    sendMatrix(32'h4000_0000, 1'b0, dc);
    checkOutput("drain cycles idle", dc, 1);
    checkOutput("m01", m_mat[63:32], 32'h4000_0001);
    checkOutput("m33", m_mat[511:480], 32'h4000_000F);

    $display("[TB] vertex then matrix back to back");
    sendVertex(8'h10, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0);
    checkGap = 1'b1;
    sendMatrix(32'h4100_0000, 1'b1, dc);
    checkGap = 1'b0;
    checkOutput("drain cycles after vertex", dc, 1);

    $display("[TB] bad opcode and err_clr");
    repeat (2) @(negedge clk);
    applyStimulus(32'h0500_0000);
    s_valid = 1'b0;
    checkOutput("err after bad opcode", err, 1);
    checkOutput("s_ready after bad opcode", s_ready, 1);
    checkOutput("matrix_busy after bad opcode", matrix_busy, 0);
    sendVertex(8'h21, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004, 1'b0);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("err sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err cleared", err, 0);
    err_clr = 1'b1;
    applyStimulus(32'hFF00_0000);
    err_clr = 1'b0;
    s_valid = 1'b0;
    checkOutput("err set wins over clear", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("err cleared again", err, 0);

    $display("[TB] gapped vertex and reset mid-matrix");
    sendVertex(8'd7, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 1'b1);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus({OP_MATRIX, 24'h0});
    applyStimulus(32'hDEAD_0000);
    applyStimulus(32'hDEAD_0001);
    s_valid = 1'b0;
    checkOutput("matrix_busy mid-packet", matrix_busy, 1);
    expMat.push_back(identMat);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("m_mat after mid reset", m_mat, identMat);
    checkOutput("matrix_busy after mid reset", matrix_busy, 0);
    checkOutput("s_ready after mid reset", s_ready, 1);
    checkOutput("vx after mid reset", vx, 0);
    checkOutput("vertex id after mid reset", in_vertex_id, 0);
    sendVertex(8'h33, 32'h5, 32'h6, 32'h7, 32'h8, 1'b0);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] 50 back-to-back vertices");
    spacingPrimed = 1'b0;
    checkSpacing = 1'b1;
    for (int i = 0; i < 50; i++) begin
      sendVertex(8'(i), 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i),
                 32'h4040_0000 + 32'(i), 32'h4080_0000 + 32'(i), 1'b0);
    end
    s_valid = 1'b0;
    n = 0;
    while ((expVtx.size() != 0 || expMat.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkSpacing = 1'b0;
    checkOutput("pending vertices", expVtx.size(), 0);
    checkOutput("pending matrices", expMat.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
